// File: rtl/mem_bist.sv
// March-style self-test initiator for the 32x8 memory on the mem_interf bus.
// Writes P, reads P, writes ~P, reads ~P, and records the first mismatch.
module mem_bist #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] SEED = 8'hA5,
   parameter int ERR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_WIDTH-1:0]  err_count,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0] fail_exp,
   output logic [DATA_WIDTH-1:0] fail_got,
   output logic                  read,
   output logic                  write,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data_in,
   input  logic [DATA_WIDTH-1:0] data_out
);

   typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST = '1;
   localparam logic [ERR_WIDTH-1:0]  SAT  = '1;

   state_t                  state;
   logic                    drain;
   logic                    cmp_valid;
   logic [ADDR_WIDTH-1:0]   cmp_addr;
   logic [DATA_WIDTH-1:0]   cmp_exp;
   logic                    mismatch;
   logic [ERR_WIDTH-1:0]    err_next;

   function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
      logic [DATA_WIDTH+ADDR_WIDTH-1:0] ext;
      ext = {{DATA_WIDTH{1'b0}}, a};
      return ext[DATA_WIDTH-1:0] ^ SEED;
   endfunction

   // data_out answers the read strobe of the previous cycle
   always_comb begin
      mismatch = cmp_valid && (data_out != cmp_exp);
      err_next = err_count;
      if (mismatch && err_count != SAT)
         err_next = err_count + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         drain     <= 1'b0;
         cmp_valid <= 1'b0;
         cmp_addr  <= '0;
         cmp_exp   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_addr <= '0;
         fail_exp  <= '0;
         fail_got  <= '0;
         read      <= 1'b0;
         write     <= 1'b0;
         addr      <= '0;
         data_in   <= '0;
      end else begin
         cmp_valid <= read;
         cmp_addr  <= addr;
         cmp_exp   <= (state == RD1) ? ~pat(addr) : pat(addr);
         err_count <= err_next;
         if (mismatch && err_count == '0) begin
            fail_addr <= cmp_addr;
            fail_exp  <= cmp_exp;
            fail_got  <= data_out;
         end
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= WR0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  err_count <= '0;
                  fail_addr <= '0;
                  fail_exp  <= '0;
                  fail_got  <= '0;
                  addr      <= '0;
                  write     <= 1'b1;
                  data_in   <= pat('0);
               end
            end
            WR0: begin
               if (addr == LAST) begin
                  state   <= RD0;
                  addr    <= '0;
                  write   <= 1'b0;
                  read    <= 1'b1;
                  data_in <= '0;
               end else begin
                  addr    <= addr + 1'b1;
                  data_in <= pat(addr + 1'b1);
               end
            end
            RD0: begin
               if (drain) begin
                  drain   <= 1'b0;
                  state   <= WR1;
                  addr    <= '0;
                  write   <= 1'b1;
                  data_in <= ~pat('0);
               end else if (addr == LAST) begin
                  read  <= 1'b0;
                  drain <= 1'b1;
               end else begin
                  addr <= addr + 1'b1;
               end
            end
            WR1: begin
               if (addr == LAST) begin
                  state   <= RD1;
                  addr    <= '0;
                  write   <= 1'b0;
                  read    <= 1'b1;
                  data_in <= '0;
               end else begin
                  addr    <= addr + 1'b1;
                  data_in <= ~pat(addr + 1'b1);
               end
            end
            RD1: begin
               if (drain) begin
                  drain <= 1'b0;
                  state <= DONE;
                  addr  <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
               end else if (addr == LAST) begin
                  read  <= 1'b0;
                  drain <= 1'b1;
               end else begin
                  addr <= addr + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: memory model with fault modes, per-cycle trace
// scoreboard and end-of-run result scoreboard.
module tb_mem_bist;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, pass, read, write;
   logic [5:0] err_count;
   logic [4:0] fail_addr, addr;
   logic [7:0] fail_exp, fail_got, data_in;
   logic [7:0] data_out = 8'h00;

   int checks = 0;
   int failures = 0;
   int fault = 0;

   logic [7:0] mem [32];

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       read;
      logic       write;
      logic [4:0] addr;
      logic [7:0] data;
   } obs_t;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       pass;
      logic       read;
      logic       write;
      logic [5:0] err;
      logic [4:0] faddr;
      logic [7:0] fexp;
      logic [7:0] fgot;
   } res_t;

   obs_t trace_q[$];
   res_t res_q[$];

   mem_bist dut (
      .clk(clk), .rst(rst), .start(start),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_addr(fail_addr),
      .fail_exp(fail_exp), .fail_got(fail_got),
      .read(read), .write(write), .addr(addr),
      .data_in(data_in), .data_out(data_out)
   );

   always #5 clk = ~clk;

   // fault 1: bit0 stuck-at-0 at addr 5; fault 2: every read returns 00
   always @(posedge clk) begin
      if (write)
         mem[addr] <= (fault == 1 && addr == 5'd5) ? (data_in & 8'hFE) : data_in;
      if (read)
         data_out <= (fault == 2) ? 8'h00 : mem[addr];
   end

   function automatic logic [7:0] p(input int a);
      logic [7:0] v;
      v = 8'(a);
      return v ^ 8'hA5;
   endfunction

   function automatic obs_t exp_cycle(input int i);
      obs_t e;
      e = '0;
      e.busy = 1'b1;
      if (i < 32) begin
         e.write = 1'b1; e.addr = 5'(i); e.data = p(i);
      end else if (i < 64) begin
         e.read = 1'b1; e.addr = 5'(i - 32);
      end else if (i >= 65 && i < 97) begin
         e.write = 1'b1; e.addr = 5'(i - 65); e.data = ~p(i - 65);
      end else if (i >= 97 && i < 129) begin
         e.read = 1'b1; e.addr = 5'(i - 97);
      end
      return e;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.busy  = busy;
      o.done  = done;
      o.read  = read;
      o.write = write;
      o.addr  = (read || write) ? addr : 5'd0;
      o.data  = write ? data_in : 8'd0;
      return o;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check(tag, 64'({busy, done, pass, err_count, fail_addr, fail_exp,
                      fail_got, read, write, addr, data_in}), 64'd0);
   endtask

   task automatic run(input int mode, input bit pulse, input int stop_at, input res_t exp_res);
      obs_t e;
      res_t r, got;
      fault = mode;
      for (int i = 0; i < 130; i++) trace_q.push_back(exp_cycle(i));
      res_q.push_back(exp_res);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < 130; i++) begin
         if (i == stop_at) begin
            rst = 1'b1;
            #1 check_zero("async_reset_outputs");
            check("async_reset_state", 64'(dut.state), 64'(0));
            trace_q.delete();
            res_q.delete();
            @(negedge clk) rst = 1'b0;
            return;
         end
         e = trace_q.pop_front();
         check($sformatf("trace_c%0d", i), 64'(observe()), 64'(e));
         if (i == 0)
            check("start_clears", 64'({done, pass, err_count, fail_addr, fail_exp, fail_got}), 64'd0);
         if (i == 70) begin
            check("err_mid", 64'(err_count), (mode == 2) ? 64'd32 : 64'd0);
            if (mode == 2)
               check("first_fail_mid", 64'({fail_addr, fail_exp, fail_got}), 64'({5'd0, 8'hA5, 8'h00}));
         end
         if (pulse && i == 50) start = 1'b1;
         if (pulse && i == 51) start = 1'b0;
         @(negedge clk);
      end
      r = res_q.pop_front();
      got = {busy, done, pass, read, write, err_count, fail_addr, fail_exp, fail_got};
      check($sformatf("result_mode%0d", mode), 64'(got), 64'(r));
   endtask

   res_t good, stuck, zero;

   initial begin
      good  = '{busy:1'b0, done:1'b1, pass:1'b1, read:1'b0, write:1'b0,
                err:6'd0, faddr:5'd0, fexp:8'h00, fgot:8'h00};
      stuck = '{busy:1'b0, done:1'b1, pass:1'b0, read:1'b0, write:1'b0,
                err:6'd1, faddr:5'd5, fexp:8'h5F, fgot:8'h5E};
      zero  = '{busy:1'b0, done:1'b1, pass:1'b0, read:1'b0, write:1'b0,
                err:6'd63, faddr:5'd0, fexp:8'hA5, fgot:8'h00};

      #1 check_zero("reset_state");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_zero("idle_after_reset");

      run(0, 1'b0, -1, good);
      run(0, 1'b1, -1, good);
      run(1, 1'b0, -1, stuck);
      run(2, 1'b0, -1, zero);
      run(0, 1'b0, -1, good);
      run(0, 1'b0, 44, good);
      check_zero("idle_after_mid_reset");
      run(0, 1'b0, -1, good);

      repeat (3) @(negedge clk);
      check("done_holds", 64'({busy, done, pass, read, write}), 64'(5'b01100));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
